// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder; the datapath driven one bit per cycle by serial_adder_ctrl.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);

  assign s     = a ^ b ^ c_in;
  assign c_out = (a & b) | (a & c_in) | (b & c_in);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Sequences an external full_adder over WIDTH-bit operands, LSB first,
// with valid/ready handshakes on the operand and result sides.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_s,
  input  logic             fa_cout
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e             state_r;
  state_e             next_state_s;
  logic [WIDTH-1:0]   a_sh_r;
  logic [WIDTH-1:0]   b_sh_r;
  logic [WIDTH-1:0]   sum_sh_r;
  logic [WIDTH-1:0]   next_sum_s;
  logic [WIDTH-1:0]   sum_r;
  logic               carry_r;
  logic               c_out_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               last_s;

  // Shift-based insertion keeps this legal for WIDTH=1 (no zero-width slices).
  assign next_sum_s = (sum_sh_r >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
  assign last_s     = (cnt_r == CNT_W'(WIDTH - 1));

  assign sum   = sum_r;
  assign c_out = c_out_r;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode; handshake and full_adder drives depend on state and registers only.
  always_comb begin
    next_state_s = state_r;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    fa_a         = 1'b0;
    fa_b         = 1'b0;
    fa_cin       = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          next_state_s = RUN;
        end else begin
          next_state_s = IDLE;
        end
      end
      RUN: begin
        fa_a   = a_sh_r[0];
        fa_b   = b_sh_r[0];
        fa_cin = carry_r;
        if (last_s) begin
          next_state_s = DONE;
        end else begin
          next_state_s = RUN;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = DONE;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Operand shifters, carry, bit counter and the result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_r   <= {WIDTH{1'b0}};
      b_sh_r   <= {WIDTH{1'b0}};
      sum_sh_r <= {WIDTH{1'b0}};
      sum_r    <= {WIDTH{1'b0}};
      carry_r  <= 1'b0;
      c_out_r  <= 1'b0;
      cnt_r    <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_sh_r   <= a_in;
            b_sh_r   <= b_in;
            sum_sh_r <= {WIDTH{1'b0}};
            carry_r  <= c_in;
            cnt_r    <= {CNT_W{1'b0}};
          end
        end
        RUN: begin
          a_sh_r   <= a_sh_r >> 1;
          b_sh_r   <= b_sh_r >> 1;
          sum_sh_r <= next_sum_s;
          carry_r  <= fa_cout;
          cnt_r    <= cnt_r + CNT_W'(1);
          if (last_s) begin
            sum_r   <= next_sum_s;
            c_out_r <= fa_cout;
          end
        end
        default: begin
          sum_r <= sum_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl (WIDTH=8 and WIDTH=1 builds).
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       in_valid = 1'b0, out_ready = 1'b0, c_in = 1'b0;
  logic [7:0] a_in = 8'h00, b_in = 8'h00;
  logic       in_ready, out_valid, c_out, fa_a, fa_b, fa_cin, fa_s, fa_cout;
  logic [7:0] sum;

  logic       in_valid1 = 1'b0, out_ready1 = 1'b0, c_in1 = 1'b0;
  logic [0:0] a_in1 = 1'b0, b_in1 = 1'b0;
  logic       in_ready1, out_valid1, c_out1, fa_a1, fa_b1, fa_cin1, fa_s1, fa_cout1;
  logic [0:0] sum1;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .c_in(c_in), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .c_out(c_out), .fa_a(fa_a),
    .fa_b(fa_b), .fa_cin(fa_cin), .fa_s(fa_s), .fa_cout(fa_cout)
  );

  full_adder fa8 (.a(fa_a), .b(fa_b), .c_in(fa_cin), .s(fa_s), .c_out(fa_cout));

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a_in(a_in1), .b_in(b_in1), .c_in(c_in1), .out_valid(out_valid1),
    .out_ready(out_ready1), .sum(sum1), .c_out(c_out1), .fa_a(fa_a1),
    .fa_b(fa_b1), .fa_cin(fa_cin1), .fa_s(fa_s1), .fa_cout(fa_cout1)
  );

  full_adder fa1 (.a(fa_a1), .b(fa_b1), .c_in(fa_cin1), .s(fa_s1), .c_out(fa_cout1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [7:0] a, input logic [7:0] b, input logic c);
    a_in = a; b_in = b; c_in = c; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // Counts edges from acceptance to out_valid, recording fa_cin for each bit.
  task automatic wait_done(output int cyc, output logic [7:0] trace);
    cyc = 0;
    trace = 8'h00;
    while (!out_valid && cyc < 20) begin
      if (cyc < 8) trace[cyc] = fa_cin;
      step();
      cyc = cyc + 1;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic [7:0] exp_sum, input logic exp_c,
                        input logic [7:0] exp_trace);
    int         cyc;
    logic [7:0] trace;
    start(a, b, c);
    check({tag, "_busy"}, in_ready, 1'b0);
    wait_done(cyc, trace);
    check({tag, "_latency"}, cyc, 32'd8);
    check({tag, "_sum"}, sum, exp_sum);
    check({tag, "_cout"}, c_out, exp_c);
    check({tag, "_carries"}, trace, exp_trace);
    release_result();
    check({tag, "_idle"}, {in_ready, out_valid}, 2'b10);
  endtask

  initial begin
    int         cyc;
    logic [7:0] trace;

    step();
    step();
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_sum", sum, 8'h00);
    check("rst_cout", c_out, 1'b0);
    check("rst_fa", {fa_a, fa_b, fa_cin}, 3'b000);
    check("rst_w1", {in_ready1, out_valid1, sum1, c_out1}, 4'b1000);
    rst_n = 1'b1;
    step();

    run_op("add5a3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 8'hF0);
    run_op("addff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 8'hFE);
    run_op("addffff", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 8'hFF);
    run_op("add0000", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);

    // Backpressure: result held in DONE while new operands are offered.
    start(8'h12, 8'h34, 1'b0);
    wait_done(cyc, trace);
    check("bp_latency", cyc, 32'd8);
    a_in = 8'h77; b_in = 8'h77;
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0] ? 1'b0 : 1'b1;
      step();
      check("bp_valid", out_valid, 1'b1);
      check("bp_ready", in_ready, 1'b0);
      check("bp_sum", sum, 8'h46);
    end
    in_valid = 1'b0;
    release_result();
    check("bp_idle", {in_ready, out_valid}, 2'b10);
    check("bp_sum_hold", sum, 8'h46);
    start(8'h01, 8'h02, 1'b0);
    check("bp_accept", in_ready, 1'b0);
    wait_done(cyc, trace);
    check("bp_next_sum", sum, 8'h03);
    release_result();

    // Reset during the third RUN cycle discards the operation.
    start(8'hAB, 8'hCD, 1'b1);
    step();
    step();
    check("mid_running", in_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", in_ready, 1'b1);
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_sum", sum, 8'h00);
    check("mid_rst_fa", {fa_a, fa_b, fa_cin, c_out}, 4'b0000);
    step();
    rst_n = 1'b1;
    step();
    run_op("add1020", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 8'h00);

    // WIDTH=1 build: a single RUN cycle.
    a_in1 = 1'b1; b_in1 = 1'b1; c_in1 = 1'b1; in_valid1 = 1'b1;
    step();
    in_valid1 = 1'b0;
    check("w1_run", {in_ready1, out_valid1, fa_cin1}, 3'b001);
    step();
    check("w1_valid", out_valid1, 1'b1);
    check("w1_sum", sum1, 1'b1);
    check("w1_cout", c_out1, 1'b1);
    out_ready1 = 1'b1;
    step();
    out_ready1 = 1'b0;
    check("w1_idle", {in_ready1, out_valid1}, 2'b10);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
